// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave receive and transmit paths.
// Holds the frame state encoding and the default frame width and idle word.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } spi_state_e;

    localparam int          SPI_DATA_WIDTH = 16;
    localparam logic [15:0] SPI_IDLE_WORD  = 16'hFFFF;

endpackage

// File: rtl/spi_edge_sync.sv
// Brings an asynchronous SPI pin into the clock domain through a SYNC_STAGES-deep
// synchroniser and flags its rising and falling edges with single-cycle pulses.
module spi_edge_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values and the chain cannot collapse into one stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
            hist_q <= RESET_LEVEL;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    // Pulses are combinational so the consumer acts SYNC_STAGES+1 edges after the pin moves.
    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/adc_spi_out.sv
// SPI mode-0 slave transmitter: shifts a held word out on MISO, MSB first, under
// the master's NSS/SCK, with a valid/ready holding register on the core side.
module adc_spi_out
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = DATA_WIDTH'(SPI_IDLE_WORD)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  spi_nss,
    input  logic                  spi_clock_in,
    output logic                  spi_data_out,
    output logic                  spi_data_oe,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic                  underrun
);

    localparam int             CW       = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_WIDTH);

    logic nss_rise, nss_fall, sck_rise, sck_fall;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_nss_sync (
        .clock   (clock),
        .reset   (reset),
        .async_in(spi_nss),
        .rise    (nss_rise),
        .fall    (nss_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sck_sync (
        .clock   (clock),
        .reset   (reset),
        .async_in(spi_clock_in),
        .rise    (sck_rise),
        .fall    (sck_fall)
    );

    spi_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  done_q, done_d;
    logic                  abort_q, abort_d;
    logic                  urun_q, urun_d;
    logic                  accept;

    assign accept = data_valid & ~hold_full_q;

    // NOTE: every signal driven here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        urun_d      = 1'b0;

        if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (nss_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    // A word offered in the start cycle bypasses the holding register.
                    if (accept) begin
                        shift_d     = data_in;
                        hold_full_d = 1'b0;
                    end else if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        shift_d = IDLE_WORD;
                        urun_d  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (nss_rise) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (sck_rise) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == LAST_BIT) state_d = DONE;
                end else if (sck_fall) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                end
            end
            DONE: begin
                if (nss_rise) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= IDLE_WORD;
            hold_full_q <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            urun_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            hold_full_q <= hold_full_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            urun_q      <= urun_d;
        end
    end

    // NOTE: hold_q is pure data qualified by hold_full_q, so it needs no reset.
    always_ff @(posedge clock) begin
        hold_q <= hold_d;
    end

    assign spi_data_oe  = (state_q != IDLE);
    assign spi_data_out = (state_q == IDLE) ? 1'b1 : shift_q[DATA_WIDTH-1];
    assign data_ready   = ~hold_full_q;
    assign frame_done   = done_q;
    assign frame_abort  = abort_q;
    assign underrun     = urun_q;

endmodule

// File: tb/tb_adc_spi_out.sv
// Bench for adc_spi_out: a mode-0 SPI master at clock/8 against a word-level model
// of the holding register, frame outcomes and status pulses.
module tb_adc_spi_out;

    localparam int DW = 16;
    localparam int SS = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          spi_nss;
    logic          spi_clock_in;
    logic          spi_data_out;
    logic          spi_data_oe;
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic          data_ready;
    logic          frame_done;
    logic          frame_abort;
    logic          underrun;

    always #5 clock = ~clock;

    adc_spi_out #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .IDLE_WORD(16'hFFFF)) dut (
        .clock       (clock),
        .reset       (reset),
        .spi_nss     (spi_nss),
        .spi_clock_in(spi_clock_in),
        .spi_data_out(spi_data_out),
        .spi_data_oe (spi_data_oe),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .underrun    (underrun)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int urun_cnt = 0;

    // Reference model: one-deep holding register seen as "a word is waiting".
    bit            m_full = 1'b0;
    logic [DW-1:0] m_word = '0;

    always @(posedge clock) begin
        #1;
        if (frame_done)  done_cnt++;
        if (frame_abort) abort_cnt++;
        if (underrun)    urun_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        spi_nss      = 1'b1;
        spi_clock_in = 1'b0;
        data_valid   = 1'b0;
        data_in      = '0;
        tick(3);
        reset  = 1'b0;
        m_full = 1'b0;
        tick(SS + 3);
    endtask

    task automatic load(input logic [DW-1:0] w);
        int t = 0;
        data_in    = w;
        data_valid = 1'b1;
        while (!data_ready && t < 400) begin
            tick(1);
            t++;
        end
        tick(1);
        data_valid = 1'b0;
        n_cmp++;
        if (t >= 400) begin
            n_mis++;
            $display("FAIL load_timeout: data_ready never rose for word %h", w);
        end
        n_cmp++;
        if (data_ready !== 1'b0) begin
            n_mis++;
            $display("FAIL load_ready_low: data_ready got %b want 0 after accepting %h", data_ready, w);
        end
        m_full = 1'b1;
        m_word = w;
    endtask

    task automatic model_start(output logic [DW-1:0] exp_word, output int exp_urun);
        exp_word = m_full ? m_word : 16'hFFFF;
        exp_urun = m_full ? 0 : 1;
        m_full   = 1'b0;
    endtask

    task automatic shift_bits(input int n, output logic [DW-1:0] rx, output int oe_bad);
        rx     = '0;
        oe_bad = 0;
        for (int i = 0; i < n; i++) begin
            spi_clock_in = 1'b1;
            rx = {rx[DW-2:0], spi_data_out};
            if (spi_data_oe !== 1'b1) oe_bad++;
            tick(4);
            spi_clock_in = 1'b0;
            tick(4);
        end
    endtask

    task automatic nss_end();
        spi_nss = 1'b1;
        tick(SS + 4);
    endtask

    task automatic check_frame(input string name, input int n, input logic [DW-1:0] rx,
                               input logic [DW-1:0] exp_word, input int oe_bad,
                               input int d0, input int a0, input int u0, input int exp_urun);
        logic [DW-1:0] exp_rx;
        exp_rx = DW'(exp_word >> (DW - n));
        n_cmp++;
        if (rx !== exp_rx) begin
            n_mis++;
            $display("FAIL %s miso: got %h want %h (%0d bits)", name, rx, exp_rx, n);
        end
        n_cmp++;
        if (oe_bad != 0) begin
            n_mis++;
            $display("FAIL %s oe_during_shift: got %0d low samples want 0", name, oe_bad);
        end
        n_cmp++;
        if (done_cnt - d0 != ((n == DW) ? 1 : 0)) begin
            n_mis++;
            $display("FAIL %s frame_done: got %0d pulses want %0d", name, done_cnt - d0, (n == DW) ? 1 : 0);
        end
        n_cmp++;
        if (abort_cnt - a0 != ((n == DW) ? 0 : 1)) begin
            n_mis++;
            $display("FAIL %s frame_abort: got %0d pulses want %0d", name, abort_cnt - a0, (n == DW) ? 0 : 1);
        end
        n_cmp++;
        if (urun_cnt - u0 != exp_urun) begin
            n_mis++;
            $display("FAIL %s underrun: got %0d pulses want %0d", name, urun_cnt - u0, exp_urun);
        end
        n_cmp++;
        if (spi_data_oe !== 1'b0 || data_ready !== !m_full) begin
            n_mis++;
            $display("FAIL %s after_frame: oe=%b ready=%b want oe=0 ready=%b", name, spi_data_oe, data_ready, !m_full);
        end
    endtask

    task automatic run_frame(input string name, input int n, input bit load_in_done, input logic [DW-1:0] w2);
        logic [DW-1:0] exp_word, rx;
        int exp_urun, oe_bad, d0, a0, u0;
        d0 = done_cnt; a0 = abort_cnt; u0 = urun_cnt;
        model_start(exp_word, exp_urun);
        spi_nss = 1'b0;
        tick(8);
        shift_bits(n, rx, oe_bad);
        tick(4);
        if (load_in_done) load(w2);
        nss_end();
        check_frame(name, n, rx, exp_word, oe_bad, d0, a0, u0, exp_urun);
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({spi_data_out, spi_data_oe, data_ready, frame_done, frame_abort, underrun} !== 6'b101000) begin
            n_mis++;
            $display("FAIL reset_outputs: got out/oe/rdy/done/abort/urun=%b%b%b%b%b%b want 101000",
                     spi_data_out, spi_data_oe, data_ready, frame_done, frame_abort, underrun);
        end
    endtask

    task automatic test_basic();
        load(16'hA5C3);
        run_frame("basic_a5c3", DW, 1'b0, '0);
    endtask

    task automatic test_underrun();
        run_frame("underrun", DW, 1'b0, '0);
    endtask

    task automatic test_abort();
        load(16'h1234);
        run_frame("abort_7", 7, 1'b0, '0);
        run_frame("after_abort", DW, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        load(16'h0001);
        run_frame("b2b_first", DW, 1'b1, 16'h8000);
        run_frame("b2b_second", DW, 1'b0, '0);
    endtask

    task automatic test_load_at_start();
        logic [DW-1:0] rx;
        int oe_bad, d0, a0, u0;
        d0 = done_cnt; a0 = abort_cnt; u0 = urun_cnt;
        spi_nss = 1'b0;
        tick(SS);
        data_in    = 16'h00FF;
        data_valid = 1'b1;
        tick(1);
        data_valid = 1'b0;
        n_cmp++;
        if (data_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL start_load_ready: data_ready got %b want 1", data_ready);
        end
        tick(5);
        shift_bits(DW, rx, oe_bad);
        tick(4);
        nss_end();
        check_frame("start_load_00ff", DW, rx, 16'h00FF, oe_bad, d0, a0, u0, 0);
    endtask

    task automatic test_reset_mid_frame();
        logic [DW-1:0] exp_word, rx;
        int exp_urun, oe_bad, d0, a0, u0;
        load(16'h5A5A);
        model_start(exp_word, exp_urun);
        d0 = done_cnt; a0 = abort_cnt; u0 = urun_cnt;
        spi_nss = 1'b0;
        tick(8);
        shift_bits(5, rx, oe_bad);
        reset = 1'b1;
        tick(1);
        n_cmp++;
        if ({spi_data_out, spi_data_oe, data_ready, frame_done, frame_abort, underrun} !== 6'b101000) begin
            n_mis++;
            $display("FAIL midreset_outputs: got out/oe/rdy/done/abort/urun=%b%b%b%b%b%b want 101000",
                     spi_data_out, spi_data_oe, data_ready, frame_done, frame_abort, underrun);
        end
        spi_nss = 1'b1;
        tick(3);
        reset  = 1'b0;
        m_full = 1'b0;
        tick(SS + 4);
        n_cmp++;
        if (done_cnt != d0 || abort_cnt != a0 || urun_cnt != u0) begin
            n_mis++;
            $display("FAIL midreset_pulses: got done/abort/urun deltas %0d/%0d/%0d want 0/0/0",
                     done_cnt - d0, abort_cnt - a0, urun_cnt - u0);
        end
        load(16'hC0DE);
        run_frame("after_midreset", DW, 1'b0, '0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            int n;
            if ($urandom_range(0, 3) != 0) load(16'($urandom));
            n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DW - 1)) : DW;
            run_frame($sformatf("random_%0d", i), n, 1'b0, '0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_abort();
        test_back_to_back();
        test_load_at_start();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
